// File: rtl/sr_pulse_driver.sv
// Button front end for a NOR SR latch: debounces set/reset buttons, issues one
// width-controlled S or R pulse per press, waits for the latch to settle and verifies Q.
module sr_pulse_driver #(
    parameter int DB_CYCLES = 4,
    parameter int PULSE_W   = 3,
    parameter int GAP       = 2,
    parameter int CNT_W     = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_btn,
    input  logic rst_btn,
    input  logic q_fb,
    output logic S,
    output logic R,
    output logic busy,
    output logic expect_q,
    output logic conflict,
    output logic mismatch
);

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    logic [1:0] w_btn_raw;
    logic [1:0] w_req;

    assign w_btn_raw = {rst_btn, set_btn};

    // Bit 0 is the set button, bit 1 the reset button.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_db
            logic             r_sync1;
            logic             r_sync2;
            logic             r_level;
            logic             r_level_d;
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_sync1   <= 1'b0;
                    r_sync2   <= 1'b0;
                    r_level   <= 1'b0;
                    r_level_d <= 1'b0;
                    r_cnt     <= '0;
                end else begin
                    r_sync1   <= w_btn_raw[gi];
                    r_sync2   <= r_sync1;
                    r_level_d <= r_level;
                    if (r_sync2 == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt >= DB_LAST) begin
                        // Count would reach DB_CYCLES on this edge: accept the new level.
                        r_level <= r_sync2;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
            end

            assign w_req[gi] = r_level & ~r_level_d;
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_pend;
    logic             w_pend_next;
    logic             r_s;
    logic             w_s_next;
    logic             r_r;
    logic             w_r_next;
    logic             r_busy;
    logic             w_busy_next;
    logic             r_expq;
    logic             w_expq_next;
    logic             r_conf;
    logic             w_conf_next;
    logic             r_mism;
    logic             w_mism_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_busy  <= 1'b0;
            r_expq  <= 1'b0;
            r_conf  <= 1'b0;
            r_mism  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_pend  <= w_pend_next;
            r_s     <= w_s_next;
            r_r     <= w_r_next;
            r_busy  <= w_busy_next;
            r_expq  <= w_expq_next;
            r_conf  <= w_conf_next;
            r_mism  <= w_mism_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_pend_next  = r_pend;
        w_expq_next  = r_expq;
        w_mism_next  = r_mism;
        w_conf_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req[0] && w_req[1]) begin
                    w_conf_next = 1'b1;
                end else if (w_req[0] || w_req[1]) begin
                    w_state_next = ST_PULSE;
                    w_pend_next  = w_req[0];
                    w_cnt_next   = CNT_ONE;
                end
            end
            ST_PULSE: begin
                if (r_cnt >= PULSE_LAST) begin
                    w_state_next = ST_GAP;
                    w_cnt_next   = CNT_ONE;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            ST_GAP: begin
                if (r_cnt >= GAP_LAST) begin
                    w_state_next = ST_CHECK;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            ST_CHECK: begin
                w_expq_next  = r_pend;
                w_mism_next  = r_mism | (q_fb != r_pend);
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
        // Drives derive from one pend bit, so S and R can never be high together.
        w_s_next    = (w_state_next == ST_PULSE) &&  w_pend_next;
        w_r_next    = (w_state_next == ST_PULSE) && !w_pend_next;
        w_busy_next = (w_state_next != ST_IDLE);
    end

    assign S        = r_s;
    assign R        = r_r;
    assign busy     = r_busy;
    assign expect_q = r_expq;
    assign conflict = r_conf;
    assign mismatch = r_mism;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Scoreboard bench for sr_pulse_driver: each stimulus step pushes the expected
// output vector for the coming edge; a monitor pops and compares after the edge.
module tb_sr_pulse_driver;

    localparam int DB = 4;
    localparam int PW = 3;
    localparam int GP = 2;
    localparam int LAT = DB + 2;

    logic clk = 1'b0;
    logic rst_n, set_btn, rst_btn, q_fb;
    logic S, R, busy, expect_q, conflict, mismatch;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    string cur_tag = "reset";

    // {S, R, busy, conflict, mismatch, expect_q}
    logic [5:0] sb[$];

    logic m_expq = 1'b0;
    logic m_mism = 1'b0;

    sr_pulse_driver #(
        .DB_CYCLES(DB),
        .PULSE_W  (PW),
        .GAP      (GP),
        .CNT_W    (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_btn (set_btn),
        .rst_btn (rst_btn),
        .q_fb    (q_fb),
        .S       (S),
        .R       (R),
        .busy    (busy),
        .expect_q(expect_q),
        .conflict(conflict),
        .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%b want=%b (S R busy conflict mismatch expect_q)",
                     tag, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        logic [5:0] exp_v;
        cyc++;
        #1;
        check("s_and_r_exclusive", {5'b0, S & R}, 6'b0);
        if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            check(cur_tag, {S, R, busy, conflict, mismatch, expect_q}, exp_v);
        end
    end

    // kind: 0 idle, 1 set, 2 reset, 3 both, 4 bounce.
    // rst_at >= 0 pulls rst_n low from that step for two edges; abort_i >= 0 raises rst_btn then.
    task automatic run(input string tag, input int kind, input logic qfb, input int len,
                       input int rst_at, input int abort_i);
        logic s_e, r_e, b_e, c_e, act;
        logic pend;
        pend = (kind == 1);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            cur_tag = tag;
            set_btn = (kind == 1) || (kind == 3) || ((kind == 4) && (i < 20) && (i % 2 == 0));
            rst_btn = (kind == 2) || (kind == 3) || ((kind == 1) && (abort_i >= 0) && (i >= abort_i));
            q_fb = qfb;
            rst_n = 1'b1;
            if (rst_at >= 0 && i >= rst_at) begin
                set_btn = 1'b0;
                rst_btn = 1'b0;
                rst_n = (i >= rst_at + 2);
            end
            s_e = 1'b0; r_e = 1'b0; b_e = 1'b0; c_e = 1'b0;
            if ((kind == 1 || kind == 2) && (rst_at < 0 || i < rst_at)) begin
                act = (i >= LAT) && (i < LAT + PW);
                s_e = act && pend;
                r_e = act && !pend;
                b_e = (i >= LAT) && (i < LAT + PW + GP + 1);
                if (i == LAT + PW + GP + 1) begin
                    m_expq = pend;
                    m_mism = m_mism | (qfb != pend);
                end
            end
            if (kind == 3 && i == LAT) c_e = 1'b1;
            if (rst_at >= 0 && i == rst_at) begin
                m_expq = 1'b0;
                m_mism = 1'b0;
            end
            sb.push_back({s_e, r_e, b_e, c_e, m_mism, m_expq});
        end
        $display("txn %s kind=%0d q_fb=%0d len=%0d expect_q=%0d mismatch=%0d",
                 tag, kind, qfb, len, m_expq, m_mism);
    endtask

    task automatic idle(input int len);
        run("idle", 0, q_fb, len, -1, -1);
    endtask

    initial begin
        rst_n = 1'b0;
        set_btn = 1'b1;
        rst_btn = 1'b0;
        q_fb = 1'b0;
        sb.push_back(6'b0);
        @(negedge clk);
        sb.push_back(6'b0);
        idle(10);

        run("set_q1", 1, 1'b1, 16, -1, -1);
        idle(10);
        run("bounce", 4, 1'b1, 32, -1, -1);
        idle(4);
        run("simultaneous", 3, 1'b1, 14, -1, -1);
        idle(10);
        run("reset_bad_q", 2, 1'b1, 16, -1, -1);
        idle(10);
        run("set_after_mism", 1, 1'b1, 16, -1, -1);
        idle(10);
        run("set_reissue", 1, 1'b1, 16, -1, -1);
        idle(10);
        run("rstn_clears", 0, 1'b1, 6, 2, -1);
        run("reset_good_q", 2, 1'b0, 16, -1, -1);
        idle(10);
        run("busy_drop", 1, 1'b1, 18, -1, 4);
        idle(10);
        run("abort_mid_pulse", 1, 1'b1, 16, 7, -1);
        idle(10);
        run("set_after_abort", 1, 1'b1, 16, -1, -1);
        idle(10);

        for (int t = 0; t < 20 && sb.size() > 0; t++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain got=%0d pending want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
